pipe_stage_buf: RTL and testbench

Parametrised inter-stage pipeline buffer for the 64-bit RISC-V pipeline, replacing fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries an opaque data payload and a control-bit vector between stages under a valid/ready handshake. It supports stall back-pressure, flush (bubble insertion) and zeroing of control bits on bubbles, and optionally a 2-entry skid buffer that registers the upstream ready.

---
 rtl/pipe_stage_buf.sv | 161 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline buffer: opaque payload plus control bits under a
// valid/ready handshake, with stall, flush and bubble control zeroing.
// Build option: define PIPE_SKID_EN for a 2-entry skid buffer with registered
// in_ready; otherwise a single entry with in_ready combinational from out_ready.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

`ifdef PIPE_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_out_valid;
  logic [CTRL_W-1:0]   r_out_ctrl;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_load_out_in;
  logic                w_load_out_skid;
  logic                w_load_skid;

`ifdef PIPE_SKID_EN
  logic [CTRL_W-1:0]   r_skid_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic                r_in_ready;
`endif

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Next-state and register-load decisions; flush overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt   = ST_ONE;
          w_load_out_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out_in = 1'b1;
`ifdef PIPE_SKID_EN
        end else if (w_in_xfer) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
`endif
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
`ifdef PIPE_SKID_EN
      ST_TWO: begin
        if (w_out_xfer) begin
          w_state_nxt     = ST_ONE;
          w_load_out_skid = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) begin
      w_state_nxt     = ST_EMPTY;
      w_load_out_in   = 1'b0;
      w_load_out_skid = 1'b0;
      w_load_skid     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // Output entry: valid follows occupancy, ctrl zeroed whenever no entry is held,
  // data only changes when a new entry is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_ctrl  <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= (w_state_nxt != ST_EMPTY);
      if (w_load_out_in) begin
        r_out_ctrl <= in_ctrl;
        r_out_data <= in_data;
`ifdef PIPE_SKID_EN
      end else if (w_load_out_skid) begin
        r_out_ctrl <= r_skid_ctrl;
        r_out_data <= r_skid_data;
`endif
      end else if (w_state_nxt == ST_EMPTY) begin
        r_out_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_SKID_EN
  // Skid entry catches the word accepted during a downstream stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (w_load_skid) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end
  end

  // Registered upstream ready: low only while both entries are held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_state_nxt != ST_TWO);
  end

  assign in_ready = r_in_ready;
`else
  // Single entry can accept when empty or when it drains this same cycle.
  assign in_ready = (r_state == ST_EMPTY) || out_ready;

  // Load-from-skid path does not exist without the skid entry.
  logic w_unused;
  assign w_unused = w_load_out_skid | w_load_skid;
`endif

  assign out_valid = r_out_valid;
  assign out_ctrl  = r_out_ctrl & {CTRL_W{r_out_valid}};
  assign out_data  = r_out_data;
  assign occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, bubbles, stall, flush and
// asynchronous reset, with expected values written out by hand for each step.
module tb_pipe_stage_buf;
  localparam int unsigned DW = 256;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [CW-1:0] c,
                           input logic [DW-1:0] d, input logic [1:0] occ);
    check({tag, ".valid"}, DW'(out_valid), DW'(v));
    check({tag, ".ctrl"},  DW'(out_ctrl),  DW'(c));
    check({tag, ".data"},  out_data,       d);
    check({tag, ".occ"},   DW'(occupancy), DW'(occ));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check_out("reset", 1'b0, 8'h00, '0, 2'd0);
    check("reset.in_ready", DW'(in_ready), DW'(1'b1));
    reset = 1'b0;

    // Streaming at full rate
    in_valid  = 1'b1;
    in_ctrl   = 8'h5A;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      step();
      check_out($sformatf("stream%0d", i), 1'b1, 8'h5A, DW'(i), 2'd1);
    end
    in_valid = 1'b0;
    step();
    check_out("drain", 1'b0, 8'h00, DW'(4), 2'd0);

    // Bubble between entries 1 and 2
    in_valid = 1'b1;
    in_data  = DW'(1);
    step();
    check_out("bub_e1", 1'b1, 8'h5A, DW'(1), 2'd1);
    in_valid = 1'b0;
    step();
    check_out("bubble", 1'b0, 8'h00, DW'(1), 2'd0);
    in_valid = 1'b1;
    in_data  = DW'(2);
    step();
    check_out("bub_e2", 1'b1, 8'h5A, DW'(2), 2'd1);
    in_valid = 1'b0;
    step();
    check_out("bub_drain", 1'b0, 8'h00, DW'(2), 2'd0);

    // Empty buffer is ready even while downstream stalls
    out_ready = 1'b0;
    #1;
    check("empty.in_ready", DW'(in_ready), DW'(1'b1));

    // Stall with entry 7 held, entry 8 waiting upstream
    in_valid = 1'b1;
    in_ctrl  = 8'h3C;
    in_data  = DW'(7);
    step();
    check_out("stall_acc7", 1'b1, 8'h3C, DW'(7), 2'd1);
    in_data = DW'(8);
`ifdef PIPE_SKID_EN
    step();
    check_out("stall_skid8", 1'b1, 8'h3C, DW'(7), 2'd2);
    check("stall_skid8.in_ready", DW'(in_ready), DW'(1'b0));
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("stall_two", 1'b1, 8'h3C, DW'(7), 2'd2);
      check("stall_two.in_ready", DW'(in_ready), DW'(1'b0));
    end
    out_ready = 1'b1;
    step();
    check_out("drain_8", 1'b1, 8'h3C, DW'(8), 2'd1);
    check("drain_8.in_ready", DW'(in_ready), DW'(1'b1));
    step();
    check_out("drain_empty", 1'b0, 8'h00, DW'(8), 2'd0);
`else
    #1;
    check("stall.in_ready", DW'(in_ready), DW'(1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall_hold", 1'b1, 8'h3C, DW'(7), 2'd1);
      check("stall_hold.in_ready", DW'(in_ready), DW'(1'b0));
    end
    out_ready = 1'b1;
    #1;
    check("unstall.in_ready", DW'(in_ready), DW'(1'b1));
    step();
    check_out("unstall_8", 1'b1, 8'h3C, DW'(8), 2'd1);
    in_valid = 1'b0;
    step();
    check_out("drain_empty", 1'b0, 8'h00, DW'(8), 2'd0);
`endif

    // Flush with a same-cycle input offer; entry 9 must never appear
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h81;
    in_data   = DW'(5);
    step();
`ifdef PIPE_SKID_EN
    in_data = DW'(6);
    step();
    check_out("pre_flush", 1'b1, 8'h81, DW'(5), 2'd2);
`else
    check_out("pre_flush", 1'b1, 8'h81, DW'(5), 2'd1);
`endif
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = DW'(9);
    step();
    check_out("flush", 1'b0, 8'h00, DW'(5), 2'd0);
    check("flush.in_ready", DW'(in_ready), DW'(1'b1));
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    check_out("post_flush", 1'b0, 8'h00, DW'(5), 2'd0);

    // Asynchronous reset in mid-cycle with entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'hFF;
    in_data   = DW'(8'hA1);
    step();
`ifdef PIPE_SKID_EN
    in_data = DW'(8'hB2);
    step();
    check_out("pre_rst", 1'b1, 8'hFF, DW'(8'hA1), 2'd2);
`else
    check_out("pre_rst", 1'b1, 8'hFF, DW'(8'hA1), 2'd1);
`endif
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 8'h00, '0, 2'd0);
    check("async_rst.in_ready", DW'(in_ready), DW'(1'b1));
    step();
    reset = 1'b0;

    // First transfer right after reset release
    in_valid  = 1'b1;
    in_ctrl   = 8'h5A;
    in_data   = DW'(3);
    out_ready = 1'b1;
    step();
    check_out("after_rst", 1'b1, 8'h5A, DW'(3), 2'd1);
    in_valid = 1'b0;
    step();
    check_out("final_drain", 1'b0, 8'h00, DW'(3), 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
